// File: rtl/cmd_saver_pkg.sv
// Shared definitions for the /CMD stream saver: FSM states and stream record constants.
package cmd_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    BLK_TYPE = 4'd1,
    BLK_LEN  = 4'd2,
    BLK_LSB  = 4'd3,
    BLK_MSB  = 4'd4,
    RD_REQ   = 4'd5,
    RD_WAIT  = 4'd6,
    BLK_DATA = 4'd7,
    EX_TYPE  = 4'd8,
    EX_LEN   = 4'd9,
    EX_LSB   = 4'd10,
    EX_MSB   = 4'd11,
    EOF      = 4'd12,
    FIN      = 4'd13
  } cmd_state_t;

  localparam logic [7:0]  CMD_BLK_DATA  = 8'h01;
  localparam logic [7:0]  CMD_BLK_EXEC  = 8'h02;
  localparam logic [7:0]  CMD_EOF       = 8'h00;
  localparam logic [16:0] CMD_MAX_CHUNK = 17'd256;

endpackage

// File: rtl/cmd_saver_chunk_calc.sv
// Picks the next block size from the remaining byte count and derives its length byte.
module cmd_chunk_calc
  import cmd_pkg::*;
(
  input  logic [16:0] remaining,
  output logic [8:0]  chunk,
  output logic [7:0]  len_byte
);

  // A remainder of 255 is split 254 + 1 so that a length byte of 1 never appears.
  always_comb begin
    chunk = 9'd0;
    if (remaining >= CMD_MAX_CHUNK) begin
      chunk = 9'd256;
    end else if (remaining == 17'd255) begin
      chunk = 9'd254;
    end else begin
      chunk = remaining[8:0];
    end
  end

  assign len_byte = chunk[7:0] + 8'd2;

endmodule

// File: rtl/cmd_saver.sv
// Streams a RAM range as /CMD data blocks plus a trailer; define CMD_SAVER_EXEC_EN
// for an exec-address trailer, otherwise a single end-of-file byte is emitted.
module cmd_saver
  import cmd_pkg::*;
#(
  parameter int DATA = 8,
  parameter int ADDR = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR-1:0] start_addr,
  input  logic [ADDR-1:0] end_addr,
  input  logic [ADDR-1:0] exec_addr,
  output logic            ram_rd,
  output logic [ADDR-1:0] ram_addr,
  input  logic [DATA-1:0] ram_data,
  output logic            out_valid,
  output logic [DATA-1:0] out_data,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam logic [ADDR-1:0] ADDR_ONE = ADDR'(1'b1);

  cmd_state_t      state_r;
  logic [ADDR-1:0] cur_addr_r;
  logic [16:0]     rem_r;
  logic [8:0]      n_r;
  logic [8:0]      chunk_s;
  logic [7:0]      len_byte_s;
  logic [15:0]     addr16_s;
  logic [ADDR-1:0] addr_next_s;
  logic            xfer_s;

`ifdef CMD_SAVER_EXEC_EN
  logic [ADDR-1:0] exec_addr_r;
  logic [15:0]     exec16_s;
  assign exec16_s = 16'(exec_addr_r);
`else
  logic            unused_exec_s;
  assign unused_exec_s = ^exec_addr;
`endif

  function automatic logic [DATA-1:0] to_data(input logic [7:0] b);
    return DATA'(b);
  endfunction

  assign xfer_s      = out_valid & out_ready;
  assign addr16_s    = 16'(cur_addr_r);
  assign addr_next_s = cur_addr_r + ADDR_ONE;

  cmd_chunk_calc u_chunk (
    .remaining (rem_r),
    .chunk     (chunk_s),
    .len_byte  (len_byte_s)
  );

  // Stream FSM: every output is registered and loaded on entry to the state that presents it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cur_addr_r <= '0;
      rem_r      <= 17'd0;
      n_r        <= 9'd0;
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef CMD_SAVER_EXEC_EN
      exec_addr_r <= '0;
`endif
    end else begin
      done   <= 1'b0;
      error  <= 1'b0;
      ram_rd <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (end_addr >= start_addr) begin
              cur_addr_r <= start_addr;
              rem_r      <= 17'(end_addr) - 17'(start_addr) + 17'd1;
`ifdef CMD_SAVER_EXEC_EN
              exec_addr_r <= exec_addr;
`endif
              busy       <= 1'b1;
              out_valid  <= 1'b1;
              out_data   <= to_data(CMD_BLK_DATA);
              state_r    <= BLK_TYPE;
            end else begin
              error <= 1'b1;
            end
          end
        end
        BLK_TYPE: begin
          if (xfer_s) begin
            n_r      <= chunk_s;
            out_data <= to_data(len_byte_s);
            state_r  <= BLK_LEN;
          end
        end
        BLK_LEN: begin
          if (xfer_s) begin
            out_data <= to_data(addr16_s[7:0]);
            state_r  <= BLK_LSB;
          end
        end
        BLK_LSB: begin
          if (xfer_s) begin
            out_data <= to_data(addr16_s[15:8]);
            state_r  <= BLK_MSB;
          end
        end
        BLK_MSB: begin
          if (xfer_s) begin
            out_valid <= 1'b0;
            ram_rd    <= 1'b1;
            ram_addr  <= cur_addr_r;
            state_r   <= RD_REQ;
          end
        end
        RD_REQ: begin
          state_r <= RD_WAIT;
        end
        RD_WAIT: begin
          out_data  <= ram_data;
          out_valid <= 1'b1;
          state_r   <= BLK_DATA;
        end
        BLK_DATA: begin
          if (xfer_s) begin
            cur_addr_r <= addr_next_s;
            n_r        <= n_r - 9'd1;
            rem_r      <= rem_r - 17'd1;
            // Decisions use the pre-decrement values, so "1 left" means "none after this byte".
            if (n_r != 9'd1) begin
              out_valid <= 1'b0;
              ram_rd    <= 1'b1;
              ram_addr  <= addr_next_s;
              state_r   <= RD_REQ;
            end else if (rem_r != 17'd1) begin
              out_data <= to_data(CMD_BLK_DATA);
              state_r  <= BLK_TYPE;
            end else begin
`ifdef CMD_SAVER_EXEC_EN
              out_data <= to_data(CMD_BLK_EXEC);
              state_r  <= EX_TYPE;
`else
              out_data <= to_data(CMD_EOF);
              state_r  <= EOF;
`endif
            end
          end
        end
`ifdef CMD_SAVER_EXEC_EN
        EX_TYPE: begin
          if (xfer_s) begin
            out_data <= to_data(8'h02);
            state_r  <= EX_LEN;
          end
        end
        EX_LEN: begin
          if (xfer_s) begin
            out_data <= to_data(exec16_s[7:0]);
            state_r  <= EX_LSB;
          end
        end
        EX_LSB: begin
          if (xfer_s) begin
            out_data <= to_data(exec16_s[15:8]);
            state_r  <= EX_MSB;
          end
        end
        EX_MSB: begin
          if (xfer_s) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= FIN;
          end
        end
`else
        EOF: begin
          if (xfer_s) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= FIN;
          end
        end
`endif
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
